// File: rtl/fusion_seq_ctrl.sv
// Sequencer for the two-track fusion datapath: loads two serial packets into
// register banks, waits for the fusion unit to settle and holds the result for downstream.

module fusion_seq_bank (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             valid,
    input  logic [2:0]       idx,
    input  logic [15:0]      x,
    input  logic [15:0]      p,
    output logic             ready,
    output logic [5:0][15:0] xb,
    output logic [5:0][15:0] pb,
    output logic             done,
    output logic             cmp,
    output logic             err,
    output logic             bbusy
);
    logic [2:0] expi;
    logic       acc;
    logic       good;

    assign ready = en & ~done;
    assign acc   = valid & ready;
    assign good  = acc & (idx == expi);
    assign cmp   = good & (idx == 3'd5);
    assign err   = acc & ~good;
    assign bbusy = done | (expi != 3'd0);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            xb   <= '0;
            pb   <= '0;
            expi <= 3'd0;
            done <= 1'b0;
        end else if (good) begin
            for (int k = 0; k < 6; k++) begin
                if (expi == 3'(k)) begin
                    xb[k] <= x;
                    pb[k] <= p;
                end
            end
            expi <= expi + 3'd1;
            if (idx == 3'd5) done <= 1'b1;
        end else if (err) begin
            // out-of-order beat: the whole partial packet is dropped
            xb   <= '0;
            pb   <= '0;
            expi <= 3'd0;
        end
    end
endmodule

module fusion_seq_ctrl #(
    parameter int FUSE_LAT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [2:0]   s1_idx,
    input  logic [15:0]  s1_x,
    input  logic [15:0]  s1_p,
    input  logic         s2_valid,
    output logic         s2_ready,
    input  logic [2:0]   s2_idx,
    input  logic [15:0]  s2_x,
    input  logic [15:0]  s2_p,
    output logic [95:0]  f_x1,
    output logic [95:0]  f_p1,
    output logic [95:0]  f_x2,
    output logic [95:0]  f_p2,
    input  logic [95:0]  f_xf,
    input  logic [191:0] f_pf,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [95:0]  out_x,
    output logic [191:0] out_p,
    output logic [1:0]   out_single,
    output logic         seq_err,
    output logic         busy
);
    typedef enum logic [1:0] {COLLECT, FUSE, HOLD} state_t;

    state_t state, state_n;

    logic [1:0]            vld, rdy, dn, cmp, err, bb, clr;
    logic [1:0][2:0]       idx;
    logic [1:0][15:0]      xin, pin;
    logic [1:0][5:0][15:0] xb, pb;
    logic [15:0]           tcnt;
    logic [3:0]            lcnt;
    logic                  cap_fuse, cap_byp;
    logic [5:0][15:0]      ox;
    logic [5:0][31:0]      op;

    assign vld = {s2_valid, s1_valid};
    assign idx = {s2_idx, s1_idx};
    assign xin = {s2_x, s1_x};
    assign pin = {s2_p, s1_p};

    for (genvar t = 0; t < 2; t++) begin : g_bank
        fusion_seq_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (state == COLLECT),
            .clr   (clr[t]),
            .valid (vld[t]),
            .idx   (idx[t]),
            .x     (xin[t]),
            .p     (pin[t]),
            .ready (rdy[t]),
            .xb    (xb[t]),
            .pb    (pb[t]),
            .done  (dn[t]),
            .cmp   (cmp[t]),
            .err   (err[t]),
            .bbusy (bb[t])
        );
    end

    assign s1_ready   = rdy[0];
    assign s2_ready   = rdy[1];
    assign f_x1       = xb[0];
    assign f_p1       = pb[0];
    assign f_x2       = xb[1];
    assign f_p2       = pb[1];
    assign out_x      = ox;
    assign out_p      = op;
    assign out_valid  = (state == HOLD);
    assign busy       = (state != COLLECT) | (|bb);

    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        cap_fuse = 1'b0;
        cap_byp  = 1'b0;
        clr      = 2'b00;
        case (state)
            COLLECT: begin
                // a completion in the expiry cycle beats the timeout
                if ((dn[0] | cmp[0]) && (dn[1] | cmp[1])) begin
                    state_n = FUSE;
                end else if ((dn[0] ^ dn[1]) && tcnt == 16'(TIMEOUT - 1)) begin
                    state_n = HOLD;
                    cap_byp = 1'b1;
                    clr     = ~dn;
                end
            end
            FUSE: begin
                if (lcnt == 4'(FUSE_LAT - 1)) begin
                    state_n  = HOLD;
                    cap_fuse = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = COLLECT;
                    clr     = 2'b11;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt       <= '0;
            lcnt       <= '0;
            ox         <= '0;
            op         <= '0;
            out_single <= 2'b00;
            seq_err    <= 1'b0;
        end else begin
            tcnt <= (state == COLLECT && (dn[0] ^ dn[1])) ? tcnt + 16'd1 : 16'd0;
            lcnt <= (state == FUSE) ? lcnt + 4'd1 : 4'd0;
            if (|err) seq_err <= 1'b1;
            if (cap_fuse) begin
                ox         <= f_xf;
                op         <= f_pf;
                out_single <= 2'b00;
            end else if (cap_byp) begin
                ox         <= dn[0] ? xb[0] : xb[1];
                out_single <= dn[0] ? 2'b01 : 2'b10;
                for (int k = 0; k < 6; k++) begin
                    op[k] <= dn[0] ? {{16{pb[0][k][15]}}, pb[0][k]}
                                   : {{16{pb[1][k][15]}}, pb[1][k]};
                end
            end
        end
    end
endmodule

// File: doc/fusion_seq_ctrl.md
Name: fusion_seq_ctrl

Overview:
- Sequencer for the two-track state fusion datapath (6-element state, 6 diagonal covariance terms per track).
- Collects one serial packet per sensor track over valid/ready streams and drives both register banks onto the combinational fusion unit.
- Waits a fixed settle latency, captures fused X/Pf, and presents them downstream with a valid/ready handshake.
- Falls back to single-track bypass on timeout; sits between the sensor front-ends and the fusion unit.

Parameters:
- FUSE_LAT, 2, cycles between driving f_* inputs and capturing f_xf/f_pf (1..15).
- TIMEOUT, 64, cycles after the first completed packet before bypassing the missing track (2..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s1_valid  in  1  track-1 beat valid
- s1_ready  out  1  track-1 beat accepted when valid&ready
- s1_idx  in  3  element index 0..5
- s1_x  in  16  signed state element
- s1_p  in  16  signed diagonal covariance element
- s2_valid, s2_ready, s2_idx, s2_x, s2_p: same as track 1, for track 2
- f_x1, f_p1, f_x2, f_p2  out  96 each  packed bank to fusion unit; element k in bits [16k+15:16k]
- f_xf  in  96  fused state from fusion unit (X0f..X5f packed)
- f_pf  in  192  fused covariance (Pf1..Pf6 packed, 32 bits each)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_x  out  96  result state
- out_p  out  192  result covariance
- out_single  out  2  01/10 = track-1/track-2 bypass result; 00 = fused
- seq_err  out  1  sticky; set on an out-of-order beat; cleared by rst only
- busy  out  1  high in any state other than COLLECT with both banks empty

Behaviour:
- States: COLLECT, FUSE, HOLD.
- Reset: state COLLECT; all banks, out_x and out_p zero; out_valid=0; out_single=00; seq_err=0; per-track expected index=0; counters zero.
- COLLECT, bank loading:
  - sN_ready=1 while bank N is incomplete; beat accepted on sN_valid&sN_ready.
  - Accepted beat with sN_idx == expected index: store x/p at that index and increment the expected index.
  - Accepting idx 5 marks bank N complete and drops sN_ready.
  - Accepted beat with a wrong idx (including 6/7): discard bank N contents, expected index to 0, set seq_err. A wrong beat carrying idx 0 is not itself stored.
  - Tracks load independently; simultaneous beats on both tracks are both accepted.
- Timeout counter:
  - Starts at 0 the cycle the first bank completes and increments while exactly one bank is complete.
  - Both banks complete: go to FUSE with lat counter = 0.
  - Counter reaches TIMEOUT-1 with one bank complete: go to HOLD directly.
    - out_x = the complete bank's x.
    - out_p element k = sign-extended p_k to 32 bits.
    - out_single marks that track.
    - The incomplete bank is cleared and its expected index reset.
    - If the other bank completes in the same cycle the timeout expires, completion wins and the FUSE path is taken.
- f_x1/f_p1/f_x2/f_p2 continuously reflect the bank registers.
- FUSE:
  - sN_ready=0; the lat counter increments each cycle.
  - When the counter equals FUSE_LAT-1: capture out_x=f_xf, out_p=f_pf, out_single=00; go to HOLD.
  - Fused result appears FUSE_LAT+1 cycles after the second bank's last beat.
- HOLD:
  - out_valid=1; out_x/out_p/out_single are stable until accepted.
  - On out_ready: out_valid falls the next cycle, both banks clear, expected indices return to 0, state returns to COLLECT.
  - sN_ready stays 0 in HOLD, so no beats are accepted.
- rst mid-operation (any state) returns everything to reset values on the next edge; a partial packet is lost.
- No arithmetic is performed in the block beyond the bypass sign extension; all counters saturate-free within the parameter ranges.

Test Plan:
- Nominal fusion:
  - Stimulus: track 1 beats x=4..9, p=12..17; track 2 beats x=9..4, p=17..12, sent concurrently; out_ready held 1.
  - Required: out_valid FUSE_LAT+1 cycles after the last beat; out_x/out_p equal the f_xf/f_pf model response; out_single=00; f_x1 element 0 = 4 and f_p2 element 5 = 12 while in FUSE.
- Staggered arrival:
  - Stimulus: track 1 completes, track 2 starts 20 cycles later (less than TIMEOUT).
  - Required: no bypass; fused result; s1_ready stays 0 after track 1's idx 5 until handoff.
- Timeout bypass:
  - Stimulus: only track 2 sends (x=9..4, p=17..12).
  - Required: exactly TIMEOUT cycles after completion, out_valid=1, out_single=10, out_x element 0 = 9, out_p element 5 = 32'd12.
- Sequence error:
  - Stimulus: track 1 sends idx 0,1,3.
  - Required: seq_err=1, bank 1 discarded; a subsequent clean 0..5 packet fuses normally; seq_err stays 1.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles in HOLD while new beats are offered.
  - Required: out_valid held with stable data, s1_ready=s2_ready=0; the result is accepted on the first out_ready=1 cycle, then the block returns to COLLECT.
- Mid-operation reset:
  - Stimulus: assert rst for one cycle in FUSE.
  - Required: next cycle all outputs are at reset values and a new nominal packet pair fuses correctly.
